// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: run/stop/single-step controller for a WIDTH-bit Johnson counter.
// A single-clock prescaler paces advances while running. A debounced-by-sync
// push-button edge requests a single advance while stopped.
//
// Ports:
//   clk       : system clock (CLOCK_50)
//   reset     : synchronous, active-high
//   run       : 1 = free-run, 0 = stop (already synchronous)
//   step_n    : asynchronous active-low push-button; each falling edge = one step
//   dir       : 0 = forward, 1 = reverse; sampled at each advance
//   rate      : tick period = 2^(BASE_SHIFT+rate) clk cycles
//   clear     : zeroes count and prescaler; state is unchanged
//   count     : Johnson register
//   tick      : one-cycle pulse in the cycle a new count is first visible
//   wrap      : one-cycle pulse when an advance lands on all-zeros
//   rev_count : number of wraps, modulo 256 (reset only)
//   state     : 00 = STOP, 01 = RUN, 10 = STEP
module johnson_seq_ctrl #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned BASE_SHIFT = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step_n,
   input  logic             dir,
   input  logic [1:0]       rate,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap,
   output logic [7:0]       rev_count,
   output logic [1:0]       state
);

   localparam int unsigned PW = BASE_SHIFT + 4;

   typedef enum logic [1:0] {
      ST_STOP = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   state_t           st_q, st_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] count_d;
   logic             tick_d, wrap_d;
   logic [7:0]       rev_d;
   logic             sync1_q, sync2_q, sync3_q;
   logic             step_ev;
   logic             adv;
   logic [PW-1:0]    t_c;
   logic [WIDTH-1:0] next_cnt;

   // Falling edge of the synchronized button; the third flop holds the previous level.
   assign step_ev = sync3_q & ~sync2_q;

   // Terminal prescaler value for the current rate; a rate change applies immediately.
   assign t_c = (PW'(1) << (BASE_SHIFT + 32'(rate))) - PW'(1);

   // Johnson successor in the direction sampled this cycle.
   assign next_cnt = dir ? {~count[0], count[WIDTH-1:1]}
                         : {count[WIDTH-2:0], ~count[WIDTH-1]};

   assign state = st_q;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q      <= ST_STOP;
         pre_q     <= '0;
         count     <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         rev_count <= '0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         sync3_q   <= 1'b1;
      end else begin
         st_q      <= st_d;
         pre_q     <= pre_d;
         count     <= count_d;
         tick      <= tick_d;
         wrap      <= wrap_d;
         rev_count <= rev_d;
         sync1_q   <= step_n;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
      end
   end

   // Next-state, prescaler and advance logic.
   always_comb begin
      st_d    = st_q;
      pre_d   = pre_q;
      count_d = count;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      rev_d   = rev_count;
      adv     = 1'b0;

      case (st_q)
         ST_STOP: begin
            pre_d = '0;
            // run wins over a coincident step request, which is dropped.
            if (run)          st_d = ST_RUN;
            else if (step_ev) st_d = ST_STEP;
         end
         ST_RUN: begin
            if (!run) begin
               st_d  = ST_STOP;
               pre_d = '0;
            end else if (pre_q >= t_c) begin
               adv   = 1'b1;
               pre_d = '0;
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         ST_STEP: begin
            adv  = 1'b1;
            st_d = ST_STOP;
         end
         default: st_d = ST_STOP;
      endcase

      // clear swallows any advance due this cycle, including a pending single step.
      if (clear) begin
         count_d = '0;
         pre_d   = '0;
      end else if (adv) begin
         count_d = next_cnt;
         tick_d  = 1'b1;
         if (next_cnt == '0) begin
            wrap_d = 1'b1;
            rev_d  = rev_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: a position-based reference model
// predicts every advance, the monitor matches DUT ticks against the queue.
module tb_johnson_seq_ctrl;

   localparam int unsigned W  = 4;
   localparam int unsigned BS = 2;

   logic         clk = 1'b0;
   logic         reset, run, step_n, dir, clear;
   logic [1:0]   rate;
   logic [W-1:0] count;
   logic         tick, wrap;
   logic [7:0]   rev_count;
   logic [1:0]   state;

   johnson_seq_ctrl #(.WIDTH(W), .BASE_SHIFT(BS)) dut (
      .clk(clk), .reset(reset), .run(run), .step_n(step_n), .dir(dir),
      .rate(rate), .clear(clear), .count(count), .tick(tick), .wrap(wrap),
      .rev_count(rev_count), .state(state)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [W-1:0] c;
      logic         w;
      logic [7:0]   r;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 0;

   // Reference model: position along the 2*W cycle, mode, cycles spent waiting.
   int m_mode;   // 0 stop, 1 run, 2 step
   int m_pos;
   int m_timer;
   int m_rev;
   bit h1, h2, h3;

   function automatic logic [W-1:0] pat(input int p);
      int k;
      logic [W-1:0] v;
      v = '0;
      if (p <= int'(W)) begin
         for (k = 0; k < p; k++) v[k] = 1'b1;
      end else begin
         for (k = 0; k < 2*int'(W) - p; k++) v[W-1-k] = 1'b1;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      bit ev, adv;
      int t;
      exp_t e;
      if (reset) begin
         m_mode = 0; m_pos = 0; m_timer = 0; m_rev = 0;
         h1 = 1; h2 = 1; h3 = 1;
      end else begin
         ev = !h2 && h3;
         h3 = h2; h2 = h1; h1 = step_n;
         t = (1 << (BS + rate)) - 1;
         adv = 0;
         case (m_mode)
            0: begin
               m_timer = 0;
               if (run) m_mode = 1;
               else if (ev) m_mode = 2;
            end
            1: begin
               if (!run) begin m_mode = 0; m_timer = 0; end
               else if (m_timer >= t) begin adv = 1; m_timer = 0; end
               else m_timer++;
            end
            default: begin adv = 1; m_mode = 0; end
         endcase
         if (clear) begin
            m_pos = 0; m_timer = 0;
         end else if (adv) begin
            m_pos = dir ? (m_pos + 2*W - 1) % (2*W) : (m_pos + 1) % (2*W);
            if (m_pos == 0) m_rev = (m_rev + 1) % 256;
            e.c = pat(m_pos); e.w = (m_pos == 0); e.r = 8'(m_rev);
            q.push_back(e);
         end
      end
   end

   // Monitor: every cycle compare level outputs; on each tick pop the expected advance.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         n_cmp++;
         if (state != 2'(m_mode) || count != pat(m_pos) || rev_count != 8'(m_rev)) begin
            n_bad++;
            $display("FAIL level: state=%0d count=%b rev=%0d, required state=%0d count=%b rev=%0d",
                     state, count, rev_count, m_mode, pat(m_pos), m_rev);
         end
         if (tick) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL tick: unexpected tick count=%b, required no tick", count);
            end else begin
               e = q.pop_front();
               if (count != e.c || wrap != e.w || rev_count != e.r) begin
                  n_bad++;
                  $display("FAIL advance: count=%b wrap=%b rev=%0d, required count=%b wrap=%b rev=%0d",
                           count, wrap, rev_count, e.c, e.w, e.r);
               end
            end
         end else begin
            n_cmp++;
            if (q.size() != 0 || wrap) begin
               n_bad++;
               $display("FAIL notick: tick=0 wrap=%b pending=%0d, required tick=%0d wrap=0",
                        wrap, q.size(), (q.size() != 0));
               q.delete();
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic press;
      step_n = 1'b0; cyc(10);
      step_n = 1'b1; cyc(4);
   endtask

   initial begin
      int hold;
      reset = 1; run = 0; step_n = 1; dir = 0; rate = 0; clear = 0;
      cyc(1);
      mon_en = 1;
      cyc(1);
      reset = 0;
      chk("reset_count", 8'(count), 8'h00);
      chk("reset_state", 8'(state), 8'h00);
      chk("reset_rev", rev_count, 8'h00);

      // Free-run forward through one full cycle.
      run = 1; cyc(34);
      run = 0; cyc(2);
      chk("run_rev", rev_count, 8'd1);
      chk("run_count", 8'(count), 8'h00);

      // Two forward steps to 0011, then one reverse step back to 0001.
      press; press;
      chk("fwd2", 8'(count), 8'b0011);
      dir = 1; press;
      chk("rev1", 8'(count), 8'b0001);

      // From reset, reverse steps then a forward step.
      reset = 1; cyc(1); reset = 0;
      press;
      chk("rev_from0", 8'(count), 8'b1000);
      chk("rev_nowrap", rev_count, 8'd0);
      press;
      chk("rev_second", 8'(count), 8'b1100);
      dir = 0; press;
      chk("fwd_back", 8'(count), 8'b1000);

      // Rate 3, drop to rate 0 with prescaler at 20.
      rate = 3; run = 1; cyc(1); cyc(20);
      rate = 0; cyc(14);
      run = 0; cyc(2);

      // clear exactly when an advance is due.
      run = 1; cyc(1); cyc(3);
      clear = 1; cyc(1); clear = 0;
      chk("clear_count", 8'(count), 8'h00);
      chk("clear_tick", 8'(tick), 8'h00);
      cyc(6); run = 0; cyc(2);

      // step_ev coincident with run rising, then reset mid-run.
      step_n = 0; cyc(2);
      run = 1; cyc(1);
      chk("coinc_state", 8'(state), 8'h01);
      step_n = 1; cyc(6);
      reset = 1; cyc(1); reset = 0;
      chk("midrun_state", 8'(state), 8'h00);
      chk("midrun_count", 8'(count), 8'h00);
      run = 0; cyc(2);

      // Randomized phase.
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) run = ~run;
         if (hold == 0) begin
            step_n = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
         end
         hold--;
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         if ($urandom_range(0, 99) == 0) rate = 2'($urandom_range(0, 3));
         clear = ($urandom_range(0, 79) == 0);
         reset = ($urandom_range(0, 499) == 0);
         cyc(1);
      end
      reset = 0; clear = 0; run = 0; step_n = 1;
      cyc(6);
      chk("queue_empty", 8'(q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
